// File: rtl/simple_mac_pkg.sv
// Shared definitions for the MII receive and transmit MACs.
// State encodings, preamble/SFD nibbles and CRC-32 constants.
package simple_mac_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;
    localparam logic [1:0] ST_DROP     = 2'd3;

    localparam logic [3:0] PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0] SFD_NIBBLE      = 4'hD;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
    } rx_beat_t;

endpackage

// File: rtl/simple_mac_rx_if.sv
// MII receive pins plus the received byte stream and statistics.
// master = the MAC side, slave = PHY/host side.
interface simple_mac_rx_if;

    logic        eth_rxdv;
    logic        eth_rxer;
    logic [3:0]  eth_rxd;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sop;
    logic        rx_eop;
    logic        rx_err;
    logic [15:0] stat_good;
    logic [15:0] stat_bad;

    modport master (
        input  eth_rxdv, eth_rxer, eth_rxd,
        output rx_data, rx_valid, rx_sop, rx_eop, rx_err,
        output stat_good, stat_bad
    );

    modport slave (
        output eth_rxdv, eth_rxer, eth_rxd,
        input  rx_data, rx_valid, rx_sop, rx_eop, rx_err,
        input  stat_good, stat_bad
    );

endinterface

// File: rtl/simple_mac_crc32_byte.sv
// Combinational next-CRC for one byte, reflected CRC-32 (LSB first).
// Shared by the receive and transmit paths.
module simple_mac_crc32_byte
    import simple_mac_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // bit-serial CRC unrolled over the 8 data bits
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ data[i]) ? CRC32_POLY_REFL : 32'h0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/simple_mac_rx.sv
// MII receive MAC: preamble strip, nibble assembly, FCS/length check.
// Optional statistics counters enabled by SIMPLE_MAC_RX_STATS_EN.
module simple_mac_rx
    import simple_mac_pkg::*;
#(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic             eth_rxclk,
    input  logic             rst,
    simple_mac_rx_if.master  bus
);

    localparam logic [11:0] MIN_L = 12'(MIN_FRAME);
    localparam logic [11:0] MAX_L = 12'(MAX_FRAME);

    logic            dv;
    logic            er;
    logic [3:0]      rxd;
    logic [1:0]      state_q, state_d;
    logic            phase_q, phase_d;
    logic [3:0]      low_q, low_d;
    logic [11:0]     cnt_q, cnt_d;
    logic [31:0]     crc_q, crc_d;
    logic [31:0]     crc_nx;
    logic            rxer_q, rxer_d;
    logic            first_q, first_d;
    logic [4:0][7:0] dl_q, dl_d;
    logic            valid_q, valid_d;
    rx_beat_t        out_q, out_d;
    logic [7:0]      byte_w;
    logic            cnt_ge5;
    logic            end_err;

    assign dv      = bus.eth_rxdv;
    assign er      = bus.eth_rxer;
    assign rxd     = bus.eth_rxd;
    assign byte_w  = {rxd, low_q};
    assign cnt_ge5 = (cnt_q >= 12'd5);
    // dangling nibble (phase 1) at frame end means misalignment
    assign end_err = rxer_q | (crc_q != CRC32_RESIDUE)
                   | (cnt_q < MIN_L) | phase_q;

    simple_mac_crc32_byte u_crc (
        .crc_in  (crc_q),
        .data    (byte_w),
        .crc_out (crc_nx)
    );

    // framing FSM, byte assembly, 5-byte FCS delay line and emission
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        low_d   = low_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        rxer_d  = rxer_q;
        first_d = first_q;
        dl_d    = dl_q;
        valid_d = 1'b0;
        out_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (dv) begin
                    if (rxd == PREAMBLE_NIBBLE) state_d = ST_PREAMBLE;
                    else                        state_d = ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!dv) begin
                    state_d = ST_IDLE;
                end else if (rxd == SFD_NIBBLE) begin
                    state_d = ST_DATA;
                    phase_d = 1'b0;
                    cnt_d   = 12'd0;
                    crc_d   = CRC32_INIT;
                    rxer_d  = 1'b0;
                    first_d = 1'b1;
                end else if (rxd != PREAMBLE_NIBBLE) begin
                    state_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!dv) begin
                    state_d = ST_IDLE;
                    first_d = 1'b0;
                    if (cnt_ge5) begin
                        valid_d    = 1'b1;
                        out_d.data = dl_q[4];
                        out_d.sop  = first_q;
                        out_d.eop  = 1'b1;
                        out_d.err  = end_err;
                    end
                end else begin
                    if (er) rxer_d = 1'b1;
                    if (!phase_q) begin
                        low_d   = rxd;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        crc_d   = crc_nx;
                        cnt_d   = cnt_q + 12'd1;
                        dl_d    = {dl_q[3:0], byte_w};
                        if (cnt_ge5) begin
                            valid_d    = 1'b1;
                            out_d.data = dl_q[4];
                            out_d.sop  = first_q;
                            first_d    = 1'b0;
                            if (cnt_q == MAX_L) begin
                                out_d.eop = 1'b1;
                                out_d.err = 1'b1;
                                state_d   = ST_DROP;
                            end
                        end
                    end
                end
            end
            default: begin
                if (!dv) state_d = ST_IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge eth_rxclk) begin
        if (rst) begin
            state_q <= ST_DROP;
            phase_q <= 1'b0;
            low_q   <= 4'h0;
            cnt_q   <= 12'd0;
            crc_q   <= CRC32_INIT;
            rxer_q  <= 1'b0;
            first_q <= 1'b0;
            dl_q    <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            low_q   <= low_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            rxer_q  <= rxer_d;
            first_q <= first_d;
            dl_q    <= dl_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign bus.rx_valid = valid_q;
    assign bus.rx_data  = out_q.data;
    assign bus.rx_sop   = out_q.sop;
    assign bus.rx_eop   = out_q.eop;
    assign bus.rx_err   = out_q.err;

`ifdef SIMPLE_MAC_RX_STATS_EN
    logic [15:0] good_q, bad_q;
    logic        ev_good, ev_bad;
    logic        idle_err, runt_end, eop_now;

    assign idle_err = (state_q == ST_IDLE) & dv & (rxd != PREAMBLE_NIBBLE);
    assign runt_end = (state_q == ST_DATA) & ~dv & ~cnt_ge5;
    assign eop_now  = valid_d & out_d.eop;
    assign ev_good  = eop_now & ~out_d.err;
    assign ev_bad   = (eop_now & out_d.err) | idle_err | runt_end;

    // saturating per-frame good/bad counters
    always_ff @(posedge eth_rxclk) begin
        if (rst) begin
            good_q <= 16'h0;
            bad_q  <= 16'h0;
        end else begin
            if (ev_good && good_q != 16'hFFFF) good_q <= good_q + 16'h1;
            if (ev_bad && bad_q != 16'hFFFF)   bad_q  <= bad_q + 16'h1;
        end
    end

    assign bus.stat_good = good_q;
    assign bus.stat_bad  = bad_q;
`else
    assign bus.stat_good = 16'h0;
    assign bus.stat_bad  = 16'h0;
`endif

endmodule

// File: tb/tb_simple_mac_rx.sv
// Self-checking bench for simple_mac_rx: frame table plus scoreboard.
// Stats checks follow SIMPLE_MAC_RX_STATS_EN.
module tb_simple_mac_rx;
    import simple_mac_pkg::*;

    logic eth_rxclk = 1'b0;
    logic rst = 1'b1;

    simple_mac_rx_if bus();

    simple_mac_rx dut (
        .eth_rxclk (eth_rxclk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 eth_rxclk = ~eth_rxclk;

    typedef struct {
        int len;
        int flip;
        int rxer_nib;
        bit extra;
        int nout;
        bit err;
    } vec_t;

    vec_t     vecs[10];
    rx_beat_t sbq[$];
    int       total = 0;
    int       bad = 0;
    int       exp_good = 0;
    int       exp_bad = 0;

    // scoreboard: every output byte must match the queue head
    always @(negedge eth_rxclk) begin
        rx_beat_t got;
        rx_beat_t e;
        if (bus.rx_valid) begin
            got = '{bus.rx_data, bus.rx_sop, bus.rx_eop, bus.rx_err};
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_byte: got %02h sop=%0b eop=%0b err=%0b, required no output",
                         got.data, got.sop, got.eop, got.err);
            end else begin
                e = sbq.pop_front();
                if (got != e) begin
                    bad++;
                    $display("FAIL byte: got %02h sop=%0b eop=%0b err=%0b, required %02h sop=%0b eop=%0b err=%0b",
                             got.data, got.sop, got.eop, got.err,
                             e.data, e.sop, e.eop, e.err);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drv(input bit dv, input logic [3:0] d, input bit er);
        bus.eth_rxdv = dv;
        bus.eth_rxd  = d;
        bus.eth_rxer = er;
        @(posedge eth_rxclk);
        #1;
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                            input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic build(input int len, input int seed,
                         output logic [7:0] fr[$]);
        logic [31:0] c;
        logic [7:0]  b;
        fr.delete();
        c = 32'hFFFFFFFF;
        for (int j = 0; j < len; j++) begin
            b = 8'((j * 7 + seed * 13 + 1) & 255);
            fr.push_back(b);
            c = crc_upd(c, b);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
    endtask

    task automatic preamble();
        for (int i = 0; i < 15; i++) drv(1'b1, 4'h5, 1'b0);
        drv(1'b1, 4'hD, 1'b0);
    endtask

    task automatic check_stats(input string tag);
        logic [15:0] eg;
        logic [15:0] eb;
`ifdef SIMPLE_MAC_RX_STATS_EN
        eg = 16'(exp_good);
        eb = 16'(exp_bad);
`else
        eg = 16'h0;
        eb = 16'h0;
`endif
        total++;
        if (bus.stat_good !== eg || bus.stat_bad !== eb) begin
            bad++;
            $display("FAIL stats_%s: got good=%0d bad=%0d, required good=%0d bad=%0d",
                     tag, bus.stat_good, bus.stat_bad, eg, eb);
        end
    endtask

    task automatic check_drained(input string tag);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drained_%s: got %0d bytes still expected, required 0",
                     tag, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic send_frame(input vec_t v, input int seed);
        logic [7:0] fr[$];
        rx_beat_t   e;
        int         nib;
        build(v.len, seed, fr);
        if (v.flip >= 0) fr[v.flip] = fr[v.flip] ^ 8'h01;
        for (int j = 0; j < v.nout; j++) begin
            e.data = fr[j];
            e.sop  = (j == 0);
            e.eop  = (j == v.nout - 1);
            e.err  = (j == v.nout - 1) && v.err;
            sbq.push_back(e);
        end
        preamble();
        nib = 0;
        for (int j = 0; j < fr.size(); j++) begin
            drv(1'b1, fr[j][3:0], nib == v.rxer_nib);
            nib++;
            drv(1'b1, fr[j][7:4], nib == v.rxer_nib);
            nib++;
        end
        if (v.extra) drv(1'b1, 4'hA, 1'b0);
        for (int i = 0; i < 12; i++) drv(1'b0, 4'h0, 1'b0);
        if (v.nout == 0 || v.err) exp_bad++;
        else                      exp_good++;
        check_drained($sformatf("len%0d", v.len));
        check_stats($sformatf("len%0d", v.len));
    endtask

    initial begin
        logic [7:0] fr[$];
        rx_beat_t   e;

        vecs[0] = '{60,   -1, -1, 1'b0, 60,   1'b0};
        vecs[1] = '{60,   10, -1, 1'b0, 60,   1'b1};
        vecs[2] = '{60,   -1, 40, 1'b0, 60,   1'b1};
        vecs[3] = '{60,   -1, -1, 1'b1, 60,   1'b1};
        vecs[4] = '{36,   -1, -1, 1'b0, 36,   1'b1};
        vecs[5] = '{0,    -1, -1, 1'b0, 0,    1'b0};
        vecs[6] = '{1,    -1, -1, 1'b0, 1,    1'b1};
        vecs[7] = '{1596, -1, -1, 1'b0, 1514, 1'b1};
        vecs[8] = '{60,   -1, -1, 1'b0, 60,   1'b0};
        vecs[9] = '{1514, -1, -1, 1'b0, 1514, 1'b0};

        bus.eth_rxdv = 1'b0;
        bus.eth_rxer = 1'b0;
        bus.eth_rxd  = 4'h0;
        repeat (3) @(posedge eth_rxclk);
        #1;
        total++;
        if ({bus.rx_valid, bus.rx_sop, bus.rx_eop, bus.rx_err, bus.rx_data} !== 12'h0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%0b d=%02h, required all 0",
                     bus.rx_valid, bus.rx_data);
        end
        check_stats("reset");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drv(1'b0, 4'h0, 1'b0);

        for (int i = 0; i < 10; i++) send_frame(vecs[i], i);

        build(60, 99, fr);
        for (int j = 0; j < 15; j++) begin
            e.data = fr[j];
            e.sop  = (j == 0);
            e.eop  = 1'b0;
            e.err  = 1'b0;
            sbq.push_back(e);
        end
        preamble();
        for (int j = 0; j < 20; j++) begin
            drv(1'b1, fr[j][3:0], 1'b0);
            drv(1'b1, fr[j][7:4], 1'b0);
        end
        rst = 1'b1;
        drv(1'b1, fr[20][3:0], 1'b0);
        rst = 1'b0;
        total++;
        if ({bus.rx_valid, bus.rx_sop, bus.rx_eop, bus.rx_err, bus.rx_data} !== 12'h0) begin
            bad++;
            $display("FAIL midframe_reset: got v=%0b eop=%0b d=%02h, required all 0",
                     bus.rx_valid, bus.rx_eop, bus.rx_data);
        end
        exp_good = 0;
        exp_bad  = 0;
        drv(1'b1, fr[20][7:4], 1'b0);
        for (int j = 21; j < fr.size(); j++) begin
            drv(1'b1, fr[j][3:0], 1'b0);
            drv(1'b1, fr[j][7:4], 1'b0);
        end
        for (int i = 0; i < 12; i++) drv(1'b0, 4'h0, 1'b0);
        check_drained("after_reset");
        check_stats("after_reset");

        send_frame(vecs[0], 42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
